// File: rtl/vote_round_ctrl.sv
// Round controller for an N-voter threshold vote: collects first votes per voter
// until all have voted or the round times out, then holds the decision on a valid/ready handshake.
module vote_round_ctrl #(
    parameter int N_VOTERS  = 4,
    parameter int THRESHOLD = 3,
    parameter int TIMEOUT   = 15,
    parameter int TW        = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [N_VOTERS-1:0]               vote_valid,
    input  logic [N_VOTERS-1:0]               vote_val,
    output logic [N_VOTERS-1:0]               voted,
    output logic [$clog2(N_VOTERS+1)-1:0]     yes_count,
    output logic                              busy,
    output logic                              result_valid,
    output logic                              result,
    output logic                              timed_out,
    input  logic                              result_ready
);

    localparam int CW = $clog2(N_VOTERS+1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N_VOTERS-1:0]   voted_q, voted_d;
    logic [CW-1:0]         yes_q, yes_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  result_q, result_d;
    logic                  timed_out_q, timed_out_d;

    logic [N_VOTERS-1:0]   accept;
    logic [N_VOTERS-1:0]   accept_yes;
    logic [N_VOTERS-1:0]   voted_merge;
    logic [CW-1:0]         new_yes;
    logic [CW-1:0]         yes_merge;
    logic                  all_in;
    logic                  timer_hit;
    logic                  launch;

    // Only the first vote of each voter in a round is accepted.
    for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_accept
        assign accept[gi]     = vote_valid[gi] & ~voted_q[gi];
        assign accept_yes[gi] = accept[gi] & vote_val[gi];
    end

    always_comb begin
        new_yes = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            new_yes = new_yes + CW'(accept_yes[i]);
        end
    end

    assign voted_merge = voted_q | accept;
    assign yes_merge   = yes_q + new_yes;
    assign all_in      = &voted_merge;
    assign timer_hit   = (timer_q == TW'(TIMEOUT - 1));

    // A new round opens from IDLE, or back-to-back from DONE on the accepting cycle.
    assign launch = start & ((state_q == ST_IDLE) |
                             ((state_q == ST_DONE) & result_ready));

    always_comb begin
        state_d     = state_q;
        voted_d     = voted_q;
        yes_d       = yes_q;
        timer_d     = timer_q;
        result_d    = result_q;
        timed_out_d = timed_out_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                voted_d = voted_merge;
                yes_d   = yes_merge;
                timer_d = timer_q + TW'(1);
                // Completion takes priority over a coincident timeout.
                if (all_in || timer_hit) begin
                    state_d     = ST_DONE;
                    result_d    = (yes_merge >= CW'(THRESHOLD));
                    timed_out_d = ~all_in;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = start ? ST_COLLECT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            voted_d     = '0;
            yes_d       = '0;
            timer_d     = '0;
            result_d    = 1'b0;
            timed_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            voted_q     <= '0;
            yes_q       <= '0;
            timer_q     <= '0;
            result_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            voted_q     <= voted_d;
            yes_q       <= yes_d;
            timer_q     <= timer_d;
            result_q    <= result_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign voted        = voted_q;
    assign yes_count    = yes_q;
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;
    assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_vote_round_ctrl.sv
// Self-checking bench for vote_round_ctrl: cycle vector table, directed multi-cycle
// corner sequences, then random traffic against a round-level reference model.
module tb_vote_round_ctrl;

    localparam int N   = 4;
    localparam int TH  = 3;
    localparam int TO  = 15;
    localparam int TWW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] vote_valid;
    logic [3:0] vote_val;
    logic [3:0] voted;
    logic [2:0] yes_count;
    logic       busy;
    logic       result_valid;
    logic       result;
    logic       timed_out;
    logic       result_ready;

    int errors = 0;
    int checks = 0;

    vote_round_ctrl #(
        .N_VOTERS (N),
        .THRESHOLD(TH),
        .TIMEOUT  (TO),
        .TW       (TWW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .vote_valid  (vote_valid),
        .vote_val    (vote_val),
        .voted       (voted),
        .yes_count   (yes_count),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result),
        .timed_out   (timed_out),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       st;
        logic [3:0] vv;
        logic [3:0] vval;
        logic       rdy;
        logic [3:0] e_voted;
        logic [2:0] e_yes;
        logic       e_busy;
        logic       e_rv;
        logic       e_res;
        logic       e_to;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic [3:0] vv, input logic [3:0] vval,
                         input logic rdy);
        start        = st;
        vote_valid   = vv;
        vote_val     = vval;
        result_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-level reference: each voter's first vote is recorded (-1 = not yet voted).
    localparam int P_IDLE = 0, P_COLLECT = 1, P_DONE = 2;
    int m_phase;
    int m_rec[N];
    int m_age;
    int m_result;
    int m_to;

    function automatic int m_voted_mask();
        int m = 0;
        for (int i = 0; i < N; i++) if (m_rec[i] >= 0) m |= (1 << i);
        return m;
    endfunction

    function automatic int m_yes();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_rec[i] == 1) c++;
        return c;
    endfunction

    task automatic m_open_round();
        m_phase = P_COLLECT;
        m_age   = 0;
        for (int i = 0; i < N; i++) m_rec[i] = -1;
    endtask

    task automatic m_step(input logic st, input logic [3:0] vv, input logic [3:0] vval,
                          input logic rdy);
        case (m_phase)
            P_IDLE: if (st) m_open_round();
            P_COLLECT: begin
                for (int i = 0; i < N; i++)
                    if (vv[i] && m_rec[i] < 0) m_rec[i] = vval[i] ? 1 : 0;
                m_age++;
                if (m_voted_mask() == 4'hF || m_age == TO) begin
                    m_phase  = P_DONE;
                    m_result = (m_yes() >= TH) ? 1 : 0;
                    m_to     = (m_voted_mask() == 4'hF) ? 0 : 1;
                end
            end
            default: if (rdy) begin
                if (st) m_open_round();
                else    m_phase = P_IDLE;
            end
        endcase
    endtask

    initial begin
        int got;
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        #2;
        chk("reset_voted", voted, 0);
        chk("reset_yes", yes_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rv", result_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_timed_out", timed_out, 0);
        tick();
        tick();
        rst_n = 1'b1;

        //           st    vv     vval   rdy   voted  yes   busy  rv    res   to
        vecs[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'hF, 4'h7, 1'b0, 4'hF, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'h0, 4'h0, 1'b0, 4'hF, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'h1, 4'h1, 1'b0, 4'h1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'h6, 4'h2, 1'b0, 4'h7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'h8, 4'h0, 1'b0, 4'hF, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'h1, 4'h1, 1'b0, 4'h1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'h3, 4'h2, 1'b0, 4'h3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'h5, 4'h0, 1'b0, 4'h7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'h8, 4'h0, 1'b0, 4'hF, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};

        drive(1'b0, 4'h0, 4'h0, 1'b0);
        tick();
        for (int k = 0; k < 15; k++) begin
            drive(vecs[k].st, vecs[k].vv, vecs[k].vval, vecs[k].rdy);
            tick();
            chk($sformatf("vec%0d_voted", k), voted, vecs[k].e_voted);
            chk($sformatf("vec%0d_yes", k), yes_count, vecs[k].e_yes);
            chk($sformatf("vec%0d_busy", k), busy, vecs[k].e_busy);
            chk($sformatf("vec%0d_rv", k), result_valid, vecs[k].e_rv);
            if (vecs[k].e_rv) begin
                chk($sformatf("vec%0d_result", k), result, vecs[k].e_res);
                chk($sformatf("vec%0d_timed_out", k), timed_out, vecs[k].e_to);
            end
            $display("vec %0d: voted=%h yes=%0d busy=%0b rv=%0b res=%0b to=%0b",
                     k, voted, yes_count, busy, result_valid, result, timed_out);
        end

        // Timeout: voters 0..2 vote yes in the first COLLECT cycle, voter 3 stays silent.
        drive(1'b1, 4'h0, 4'h0, 1'b0);
        tick();
        got = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) drive(1'b0, 4'h7, 4'h7, 1'b0);
            else        drive(1'b0, 4'h0, 4'h0, 1'b0);
            tick();
            if (result_valid) begin
                got = c;
                break;
            end
        end
        chk("timeout_latency", got, TO);
        chk("timeout_result", result, 1);
        chk("timeout_timed_out", timed_out, 1);
        chk("timeout_voted", voted, 4'h7);
        chk("timeout_yes", yes_count, 3);
        $display("timeout round: latency=%0d result=%0b timed_out=%0b", got, result, timed_out);

        // Stall the handshake; late votes in DONE must not disturb the held decision.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'hF, 4'hF, 1'b0);
            tick();
            chk($sformatf("stall%0d_rv", k), result_valid, 1);
            chk($sformatf("stall%0d_voted", k), voted, 4'h7);
            chk($sformatf("stall%0d_yes", k), yes_count, 3);
            chk($sformatf("stall%0d_result", k), result, 1);
            chk($sformatf("stall%0d_timed_out", k), timed_out, 1);
        end
        drive(1'b1, 4'h0, 4'h0, 1'b1);
        tick();
        chk("restart_busy", busy, 1);
        chk("restart_rv", result_valid, 0);
        chk("restart_voted", voted, 0);
        chk("restart_yes", yes_count, 0);
        $display("back-to-back restart: busy=%0b rv=%0b voted=%h", busy, result_valid, voted);

        // Last voter arrives in the timeout cycle: completion wins.
        got = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1)       drive(1'b0, 4'h7, 4'h3, 1'b0);
            else if (c == TO) drive(1'b0, 4'h8, 4'h8, 1'b0);
            else              drive(1'b0, 4'h0, 4'h0, 1'b0);
            tick();
            if (result_valid) begin
                got = c;
                break;
            end
        end
        chk("tie_latency", got, TO);
        chk("tie_timed_out", timed_out, 0);
        chk("tie_voted", voted, 4'hF);
        chk("tie_yes", yes_count, 3);
        chk("tie_result", result, 1);
        $display("tie round: latency=%0d result=%0b timed_out=%0b", got, result, timed_out);
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        tick();

        // Reset in the middle of a round.
        drive(1'b1, 4'h0, 4'h0, 1'b0);
        tick();
        drive(1'b0, 4'h1, 4'h1, 1'b0);
        tick();
        chk("midround_voted", voted, 4'h1);
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("abort_voted", voted, 0);
        chk("abort_yes", yes_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rv", result_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_timed_out", timed_out, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'hF, 4'hF, 1'b1);
            tick();
            chk($sformatf("post_reset%0d_busy", k), busy, 0);
            chk($sformatf("post_reset%0d_rv", k), result_valid, 0);
        end
        $display("mid-round reset: busy=%0b rv=%0b", busy, result_valid);

        // Random traffic against the reference model, starting from a clean reset.
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        m_phase  = P_IDLE;
        m_age    = 0;
        m_result = 0;
        m_to     = 0;
        for (int i = 0; i < N; i++) m_rec[i] = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       st, rdy;
            logic [3:0] vv, vval;
            st   = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 2) == 0);
            vval = 4'($urandom);
            vv   = '0;
            for (int i = 0; i < N; i++) vv[i] = ($urandom_range(0, 5) == 0);
            drive(st, vv, vval, rdy);
            m_step(st, vv, vval, rdy);
            tick();
            chk("rnd_voted", voted, m_voted_mask());
            chk("rnd_yes", yes_count, m_yes());
            chk("rnd_busy", busy, (m_phase != P_IDLE) ? 1 : 0);
            chk("rnd_rv", result_valid, (m_phase == P_DONE) ? 1 : 0);
            if (m_phase == P_DONE) begin
                chk("rnd_result", result, m_result);
                chk("rnd_timed_out", timed_out, m_to);
            end
            if (cyc % 250 == 0)
                $display("rnd cyc %0d: voted=%h yes=%0d busy=%0b rv=%0b", cyc, voted,
                         yes_count, busy, result_valid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
